// File: rtl/sort_dma_master_pkg.sv
// ---------------------------------------------------------------------------
// sort_dma_pkg
// Shared types and constants for the sort_dma_master AXI4-lite copy engine.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sort_dma_pkg;

  // Transfer sequencer states; one AXI transaction in flight at a time.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_FINISH  = 3'd5
  } dma_state_e;

  localparam logic [2:0]  AXI_PROT_DATA   = 3'b000;
  localparam logic [3:0]  WSTRB_FULL      = 4'hF;
  localparam logic [31:0] WORD_BYTES      = 32'd4;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  // Byte offset of word number idx; wraps modulo 2**32 like the address bus.
  function automatic logic [31:0] word_offset(input logic [31:0] idx);
    return idx * WORD_BYTES;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sort_dma_master_if.sv
// ---------------------------------------------------------------------------
// sort_dma_master_if
// AXI4-lite bus between the copy engine (master) and memory/peripheral
// responder (slave). No response codes are carried.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sort_dma_master_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

`default_nettype wire

// File: rtl/sort_dma_master.sv
// ---------------------------------------------------------------------------
// sort_dma_master
// AXI4-lite initiator copying 2**LOG_INPUT_NUM 32-bit words from src_addr to
// dst_addr, strictly one read or write transaction at a time.
// Option macro: AXI_DMA_FIXED_DST_EN -- every write goes to the latched
// destination (streaming into a single MMIO register) instead of dst+4*count.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sort_dma_master
  import sort_dma_pkg::*;
#(
  parameter int LOG_INPUT_NUM = 3,
  parameter int DATAWIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [31:0]               src_addr,
  input  logic [31:0]               dst_addr,
  output logic                      busy,
  output logic                      done,
  sort_dma_master_if.master         mem_axi
);

  localparam int CNT_W = LOG_INPUT_NUM + 1;
  localparam logic [CNT_W-1:0] WORD_NUM = CNT_W'(2 ** LOG_INPUT_NUM);

  dma_state_e           state_q;
  logic [CNT_W-1:0]     count_q;
  logic [31:0]          src_q;
  logic [31:0]          dst_q;
  logic [DATAWIDTH-1:0] wdata_q;
  logic [31:0]          araddr_q;
  logic [31:0]          awaddr_q;
  logic [3:0]           wstrb_q;
  logic                 arvalid_q;
  logic                 rready_q;
  logic                 awvalid_q;
  logic                 wvalid_q;
  logic                 bready_q;
  logic                 busy_q;
  logic                 done_q;

  logic [CNT_W-1:0]     count_d;
  logic [31:0]          araddr_d;
  logic [31:0]          awaddr_d;
  logic                 last_word;
  logic                 aw_ok;
  logic                 w_ok;

  // Next word index and the addresses it selects.
  assign count_d   = count_q + 1'b1;
  assign last_word = (count_d == WORD_NUM);
  assign araddr_d  = src_q + word_offset(32'(count_d));
`ifdef AXI_DMA_FIXED_DST_EN
  assign awaddr_d  = dst_q;
`else
  assign awaddr_d  = dst_q + word_offset(32'(count_q));
`endif

  // A write channel is finished once its valid has dropped or handshakes now.
  assign aw_ok = !awvalid_q || mem_axi.awready;
  assign w_ok  = !wvalid_q  || mem_axi.wready;

  // Transfer sequencer with registered bus outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wstrb_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            src_q     <= src_addr & ADDR_ALIGN_MASK;
            dst_q     <= dst_addr & ADDR_ALIGN_MASK;
            araddr_q  <= src_addr & ADDR_ALIGN_MASK;
            count_q   <= '0;
            arvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_RD_ADDR;
          end
        end
        ST_RD_ADDR: begin
          if (mem_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (mem_axi.rvalid) begin
            wdata_q   <= mem_axi.rdata;
            rready_q  <= 1'b0;
            awaddr_q  <= awaddr_d;
            wstrb_q   <= WSTRB_FULL;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          // AW and W complete independently; leave only when both are done.
          if (mem_axi.awready) awvalid_q <= 1'b0;
          if (mem_axi.wready)  wvalid_q  <= 1'b0;
          if (aw_ok && w_ok) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (mem_axi.bvalid) begin
            bready_q <= 1'b0;
            count_q  <= count_d;
            if (last_word) begin
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end else begin
              araddr_q  <= araddr_d;
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_ADDR;
            end
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_axi.arvalid = arvalid_q;
  assign mem_axi.araddr  = araddr_q;
  assign mem_axi.arprot  = AXI_PROT_DATA;
  assign mem_axi.rready  = rready_q;
  assign mem_axi.awvalid = awvalid_q;
  assign mem_axi.awaddr  = awaddr_q;
  assign mem_axi.awprot  = AXI_PROT_DATA;
  assign mem_axi.wvalid  = wvalid_q;
  assign mem_axi.wdata   = wdata_q;
  assign mem_axi.wstrb   = wstrb_q;
  assign mem_axi.bready  = bready_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sort_dma_master.sv
// ---------------------------------------------------------------------------
// tb_sort_dma_master
// Directed bench for sort_dma_master with a behavioural AXI4-lite responder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sort_dma_master;

  localparam int N     = 8;
  localparam int BOUND = 1000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic        busy;
  logic        done;

  sort_dma_master_if bus();

  sort_dma_master #(.LOG_INPUT_NUM(3), .DATAWIDTH(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .busy     (busy),
    .done     (done),
    .mem_axi  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Responder state
  int          aw_stall = 0;
  int          aw_wait;
  int          rd_cnt;
  int          wr_cnt;
  int          done_cnt;
  logic        aw_got;
  logic        w_got;
  logic [31:0] wa;
  logic [31:0] wd;
  logic [31:0] rd_log [32];
  logic [31:0] wa_log [32];
  logic [31:0] wd_log [32];
  logic        aw_hs;
  logic        w_hs;

  // Monitor state
  logic        proto_err;
  logic        saw_aw_only;
  logic        ar_pend, aw_pend, w_pend;
  logic [31:0] ar_prev, aw_prev, w_prev;

  // Source memory image: 0x3000_0000.. holds 8,7,..,1; elsewhere an address tag.
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h3000_0000;
    if (off < 32'd32) return 32'd8 - (off >> 2);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign bus.arready = 1'b1;
  assign bus.wready  = 1'b1;
  assign bus.awready = bus.awvalid && (aw_wait >= aw_stall);
  assign aw_hs       = bus.awvalid && bus.awready;
  assign w_hs        = bus.wvalid && bus.wready;

  // Responder: one-cycle read latency, write response after both AW and W.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.bvalid <= 1'b0;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      wa         <= '0;
      wd         <= '0;
      aw_wait    <= 0;
      rd_cnt     <= 0;
      wr_cnt     <= 0;
    end else begin
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= rd_word(bus.araddr);
        if (rd_cnt < 32) rd_log[rd_cnt] <= bus.araddr;
        rd_cnt <= rd_cnt + 1;
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
      end
      if (bus.awvalid && !bus.awready) aw_wait <= aw_wait + 1;
      else                             aw_wait <= 0;
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (aw_hs) begin aw_got <= 1'b1; wa <= bus.awaddr; end
      if (w_hs)  begin w_got  <= 1'b1; wd <= bus.wdata;  end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        bus.bvalid <= 1'b1;
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
        if (wr_cnt < 32) begin
          wa_log[wr_cnt] <= aw_hs ? bus.awaddr : wa;
          wd_log[wr_cnt] <= w_hs ? bus.wdata : wd;
        end
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  // Protocol monitor: stable pending valids, fixed attributes, done pulses.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      proto_err   <= 1'b0;
      saw_aw_only <= 1'b0;
      done_cnt    <= 0;
      ar_pend     <= 1'b0;
      aw_pend     <= 1'b0;
      w_pend      <= 1'b0;
      ar_prev     <= '0;
      aw_prev     <= '0;
      w_prev      <= '0;
    end else begin
      if (ar_pend && (!bus.arvalid || bus.araddr != ar_prev)) proto_err <= 1'b1;
      if (aw_pend && (!bus.awvalid || bus.awaddr != aw_prev)) proto_err <= 1'b1;
      if (w_pend  && (!bus.wvalid  || bus.wdata  != w_prev))  proto_err <= 1'b1;
      if (bus.arvalid && bus.arprot != 3'b000) proto_err <= 1'b1;
      if (bus.awvalid && bus.awprot != 3'b000) proto_err <= 1'b1;
      if (bus.wvalid  && bus.wstrb  != 4'hF)   proto_err <= 1'b1;
      ar_pend <= bus.arvalid && !bus.arready;
      aw_pend <= bus.awvalid && !bus.awready;
      w_pend  <= bus.wvalid  && !bus.wready;
      ar_prev <= bus.araddr;
      aw_prev <= bus.awaddr;
      w_prev  <= bus.wdata;
      if (bus.awvalid && !bus.wvalid) saw_aw_only <= 1'b1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    start  = 1'b0;
    resetn = 1'b0;
    #1;
    check("rst_ctrl", 32'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                           bus.bready, busy, done}), 32'd0);
    check("rst_data", bus.araddr | bus.awaddr | bus.wdata | 32'(bus.wstrb), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] d);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    check("c1_busy_arvalid", 32'({busy, bus.arvalid}), 32'd3);
    check("c1_araddr", bus.araddr, s & 32'hFFFF_FFFC);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic verify_words(input logic [31:0] s, input logic [31:0] d);
    logic [31:0] ra;
    logic [31:0] wexp;
    for (int i = 0; i < N; i++) begin
      ra = (s & 32'hFFFF_FFFC) + 32'(4 * i);
`ifdef AXI_DMA_FIXED_DST_EN
      wexp = d;
`else
      wexp = d + 32'(4 * i);
`endif
      check($sformatf("araddr[%0d]", i), rd_log[i], ra);
      check($sformatf("awaddr[%0d]", i), wa_log[i], wexp);
      check($sformatf("wdata[%0d]", i), wd_log[i], rd_word(ra));
    end
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          stall;
    int          exp_done;
    logic [31:0] exp_d0;
  } vec_t;

  vec_t vecs [3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    resetn   = 1'b0;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;

    vecs[0] = '{32'h3000_0000, 32'h0000_1000, 0, 33, 32'd8};
    vecs[1] = '{32'h3000_0000, 32'h0000_2000, 3, 57, 32'd8};
    vecs[2] = '{32'hFFFF_FFF8, 32'h0000_0100, 0, 33, 32'hA5A5_FFF8};
`ifdef AXI_DMA_FIXED_DST_EN
    vecs[1].dst = 32'h4000_0004;
`endif

    for (int v = 0; v < 3; v++) begin
      apply_reset();
      aw_stall = vecs[v].stall;
      do_start(vecs[v].src, vecs[v].dst);
      wait_done(cyc);
      check("done_cycle", 32'(cyc), 32'(vecs[v].exp_done));
      @(negedge clk);
      check("idle_after_done", 32'({busy, done}), 32'd0);
      check("read_count", 32'(rd_cnt), 32'(N));
      check("write_count", 32'(wr_cnt), 32'(N));
      check("first_wdata", wd_log[0], vecs[v].exp_d0);
      check("protocol", 32'(proto_err), 32'd0);
      check("w_before_aw", 32'(saw_aw_only), 32'(vecs[v].stall > 0));
      verify_words(vecs[v].src, vecs[v].dst);
    end

    // Wrapped source addresses cross zero.
    check("wrap_ar2", rd_log[2], 32'h0000_0000);
    check("wrap_ar3", rd_log[3], 32'h0000_0004);

    // start pulsed while busy is ignored.
    apply_reset();
    aw_stall = 0;
    do_start(32'h3000_0000, 32'h0000_1000);
    cyc = 0;
    while (rd_cnt != 3 && cyc < BOUND) begin @(negedge clk); cyc++; end
    check("wait_word3", 32'(cyc < BOUND), 32'd1);
    src_addr = 32'hDEAD_0000;
    dst_addr = 32'hBEEF_0000;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(cyc);
    for (int k = 0; k < 10; k++) @(negedge clk);
    check("busy_start_reads", 32'(rd_cnt), 32'(N));
    check("busy_start_writes", 32'(wr_cnt), 32'(N));
    check("busy_start_done_pulses", 32'(done_cnt), 32'd1);
    check("busy_start_idle", 32'({busy, bus.arvalid}), 32'd0);
    verify_words(32'h3000_0000, 32'h0000_1000);

    // Reset during the fifth write, then a complete fresh copy.
    apply_reset();
    do_start(32'h3000_0000, 32'h0000_1000);
    cyc = 0;
    while (!(rd_cnt == 5 && bus.awvalid) && cyc < BOUND) begin @(negedge clk); cyc++; end
    check("wait_word5_write", 32'(cyc < BOUND), 32'd1);
    resetn = 1'b0;
    #1;
    check("midreset_valids", 32'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                                  bus.bready}), 32'd0);
    check("midreset_busy_done", 32'({busy, done}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    do_start(32'h3000_0000, 32'h0000_1000);
    wait_done(cyc);
    check("restart_done_cycle", 32'(cyc), 32'd33);
    check("restart_writes", 32'(wr_cnt), 32'(N));
    check("restart_first_wdata", wd_log[0], 32'd8);
    check("restart_last_wdata", wd_log[7], 32'd1);
    verify_words(32'h3000_0000, 32'h0000_1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
